// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the control sequencer: FSM state encodings,
// opcode class codes and the bit positions inside the control word.
package control_sequencer_pkg;

  // FSM states; the encoding is also exported on state_out for the debug display.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'b000,
    ST_FETCH  = 3'b001,
    ST_DECODE = 3'b010,
    ST_ARG    = 3'b011,
    ST_ARG_LD = 3'b100,
    ST_EXEC   = 3'b101,
    ST_HALT   = 3'b110
  } state_e;

  // Opcode class carried in bits [7:5] of the opcode byte.
  typedef enum logic [2:0] {
    CLS_NOP  = 3'b000,
    CLS_INC  = 3'b001,
    CLS_RST  = 3'b010,
    CLS_WTR  = 3'b011,
    CLS_WTA  = 3'b100,
    CLS_JMP  = 3'b101,
    CLS_JEQ  = 3'b110,
    CLS_HALT = 3'b111
  } opclass_e;

  // Control word width and bit positions.
  localparam int          CTRL_W     = 10;
  localparam logic [3:0]  CB_INC_EN  = 4'd0;
  localparam logic [3:0]  CB_RST_EN  = 4'd1;
  localparam logic [3:0]  CB_WTR_EN  = 4'd2;
  localparam logic [3:0]  CB_DR_WR   = 4'd3;
  localparam logic [3:0]  CB_PC_WR   = 4'd4;
  localparam int          CB_OPR_LSB = 5;
  localparam int          CB_OPR_MSB = 7;
  localparam logic [3:0]  CB_IRAM_RD = 4'd8;
  localparam logic [3:0]  CB_WTA_EN  = 4'd9;

endpackage

// File: rtl/control_sequencer_decoder.sv
// Combinational opcode-class decoder: tells the sequencer whether a class
// carries an operand byte and which single enable it drives in EXEC.
module opcode_decoder
  import control_sequencer_pkg::*;
(
  input  opclass_e   cls_i,
  output logic       has_operand_o,
  output logic       en_valid_o,
  output logic [3:0] en_idx_o,
  output logic       is_jmp_o,
  output logic       is_jeq_o
);

  // Full decode of all eight classes; each datapath class maps to exactly one enable bit.
  always_comb begin
    has_operand_o = 1'b0;
    en_valid_o    = 1'b0;
    en_idx_o      = 4'd0;
    is_jmp_o      = 1'b0;
    is_jeq_o      = 1'b0;
    case (cls_i)
      CLS_INC: begin
        has_operand_o = 1'b1;
        en_valid_o    = 1'b1;
        en_idx_o      = CB_INC_EN;
      end
      CLS_RST: begin
        has_operand_o = 1'b1;
        en_valid_o    = 1'b1;
        en_idx_o      = CB_RST_EN;
      end
      CLS_WTR: begin
        has_operand_o = 1'b1;
        en_valid_o    = 1'b1;
        en_idx_o      = CB_WTR_EN;
      end
      CLS_WTA: begin
        has_operand_o = 1'b1;
        en_valid_o    = 1'b1;
        en_idx_o      = CB_WTA_EN;
      end
      CLS_JMP: begin
        has_operand_o = 1'b1;
        is_jmp_o      = 1'b1;
      end
      CLS_JEQ: begin
        has_operand_o = 1'b1;
        is_jeq_o      = 1'b1;
      end
      default: begin
        // NOP and HALT: no operand, no enable
        has_operand_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Instruction sequencer: walks FETCH/DECODE/ARG/ARG_LD/EXEC for each opcode
// read from IRAM and emits a registered 10-bit control word to the datapath.
// Outputs are computed together with the next state so that the value shown
// for a state is present during the cycle the FSM sits in that state.
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int CW = 10  // control-word width; only 10 is supported
)
(
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [7:0]    instr_in,
  input  logic          eq_flag,
  output logic [CW-1:0] ctrlsig,
  output logic          pc_inc,
  output logic          busy,
  output logic          halted,
  output logic [2:0]    state_out
);

  state_e          state_q;
  opclass_e        ir_q;      // class of the instruction being executed
  logic [7:0]      tgt_q;     // JEQ target byte, held until EXEC
  logic [CW-1:0]   ctrl_q;
  logic            pc_inc_q;

  opclass_e        dec_cls;
  logic            dec_has_operand;
  logic            dec_en_valid;
  logic [3:0]      dec_en_idx;
  logic            dec_is_jmp;
  logic            dec_is_jeq;

  // In DECODE the opcode is still on the bus; afterwards the latched class is used.
  assign dec_cls = (state_q == ST_DECODE) ? opclass_e'(instr_in[7:5]) : ir_q;

  opcode_decoder u_decoder (
    .cls_i         (dec_cls),
    .has_operand_o (dec_has_operand),
    .en_valid_o    (dec_en_valid),
    .en_idx_o      (dec_en_idx),
    .is_jmp_o      (dec_is_jmp),
    .is_jeq_o      (dec_is_jeq)
  );

  // Sequencer FSM with registered control word and PC increment strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      ir_q     <= CLS_NOP;
      tgt_q    <= 8'h00;
      ctrl_q   <= '0;
      pc_inc_q <= 1'b0;
    end else begin
      // Every output bit defaults low; each branch raises only what the next state needs.
      ctrl_q   <= '0;
      pc_inc_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q            <= ST_FETCH;
            ctrl_q[CB_IRAM_RD] <= 1'b1;
            pc_inc_q           <= 1'b1;
          end
        end

        ST_FETCH: begin
          state_q <= ST_DECODE;
        end

        ST_DECODE: begin
          ir_q <= dec_cls;
          if (dec_cls == CLS_HALT) begin
            state_q <= ST_HALT;
          end else if (!dec_has_operand) begin
            // NOP: straight on to the next opcode
            state_q            <= ST_FETCH;
            ctrl_q[CB_IRAM_RD] <= 1'b1;
            pc_inc_q           <= 1'b1;
          end else begin
            state_q            <= ST_ARG;
            ctrl_q[CB_IRAM_RD] <= 1'b1;
            pc_inc_q           <= 1'b1;
          end
        end

        ST_ARG: begin
          state_q <= ST_ARG_LD;
          // Operand lands in DR for datapath classes, in PC for JMP; JEQ keeps it internally.
          if (dec_en_valid) begin
            ctrl_q[CB_DR_WR] <= 1'b1;
          end else if (dec_is_jmp) begin
            ctrl_q[CB_PC_WR] <= 1'b1;
          end
        end

        ST_ARG_LD: begin
          state_q <= ST_EXEC;
          tgt_q   <= instr_in;
          if (dec_en_valid) begin
            ctrl_q[dec_en_idx]             <= 1'b1;
            ctrl_q[CB_OPR_MSB:CB_OPR_LSB] <= ir_q;
          end else if (dec_is_jeq) begin
            // Compare result is captured at the edge entering EXEC so the PC write is registered.
            ctrl_q[CB_PC_WR] <= eq_flag;
          end
        end

        ST_EXEC: begin
          state_q            <= ST_FETCH;
          ctrl_q[CB_IRAM_RD] <= 1'b1;
          pc_inc_q           <= 1'b1;
        end

        ST_HALT: begin
          // Only reset leaves HALT
          state_q <= ST_HALT;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign ctrlsig   = ctrl_q;
  assign pc_inc    = pc_inc_q;
  assign state_out = state_q;
  assign busy      = (state_q != ST_IDLE) && (state_q != ST_HALT);
  assign halted    = (state_q == ST_HALT);

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: emulates IRAM, runs directed and
// random programs and compares every cycle against a per-instruction model.
module tb_control_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] instr_in = 8'h00;
  logic       eq_flag = 1'b0;
  logic [9:0] ctrlsig;
  logic       pc_inc;
  logic       busy;
  logic       halted;
  logic [2:0] state_out;

  int n_cmp = 0;
  int n_err = 0;
  bit inv_en = 1'b0;

  typedef struct {
    int st;
    int ctrl;
    bit pc;
    bit eq;
  } exp_t;

  logic [7:0] prog[$];
  exp_t       exp_q[$];
  int         ptr;

  control_sequencer #(.CW(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .instr_in  (instr_in),
    .eq_flag   (eq_flag),
    .ctrlsig   (ctrlsig),
    .pc_inc    (pc_inc),
    .busy      (busy),
    .halted    (halted),
    .state_out (state_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Properties that must hold in every cycle regardless of program.
  always @(negedge clk) begin
    if (inv_en) begin
      check("inv_onehot", 32'($countones({ctrlsig[9], ctrlsig[2:0]}) <= 1), 32'd1);
      check("inv_dr_pc_excl", 32'(ctrlsig[3] & ctrlsig[4]), 32'd0);
      check("inv_opr_sel", (state_out != 3'd5) ? 32'(ctrlsig[7:5]) : 32'd0, 32'd0);
      check("inv_busy", 32'(busy), 32'((state_out != 3'd0) && (state_out != 3'd6)));
      check("inv_halted", 32'(halted), 32'(state_out == 3'd6));
    end
  end

  // Expected cycle trace derived from the instruction rules: one entry per cycle.
  task automatic build_model(input int eq_mode);
    int i;
    int cls;
    int ld;
    int ex;
    bit e;
    exp_q.delete();
    i = 0;
    while (i < prog.size()) begin
      cls = int'(prog[i][7:5]);
      e = (eq_mode == 2) ? bit'($urandom_range(0, 1)) : eq_mode[0];
      exp_q.push_back('{1, 1 << 8, 1'b1, e});          // FETCH
      exp_q.push_back('{2, 0, 1'b0, e});               // DECODE
      if (cls == 0) begin
        i = i + 1;
      end else if (cls == 7) begin
        exp_q.push_back('{6, 0, 1'b0, e});             // HALT
        break;
      end else begin
        exp_q.push_back('{3, 1 << 8, 1'b1, e});        // ARG
        ld = (cls <= 4) ? (1 << 3) : (cls == 5) ? (1 << 4) : 0;
        exp_q.push_back('{4, ld, 1'b0, e});            // ARG_LD
        case (cls)
          1:       ex = (1 << 5) | (1 << 0);
          2:       ex = (2 << 5) | (1 << 1);
          3:       ex = (3 << 5) | (1 << 2);
          4:       ex = (4 << 5) | (1 << 9);
          6:       ex = e ? (1 << 4) : 0;
          default: ex = 0;
        endcase
        exp_q.push_back('{5, ex, 1'b0, e});            // EXEC
        i = i + 2;
      end
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".state"}, 32'(state_out), 32'd0);
    check({tag, ".ctrl"}, 32'(ctrlsig), 32'd0);
    check({tag, ".pc_inc"}, 32'(pc_inc), 32'd0);
    check({tag, ".busy"}, 32'(busy), 32'd0);
    check({tag, ".halted"}, 32'(halted), 32'd0);
  endtask

  // Reset with start also high: reset must win.
  task automatic do_reset();
    reset = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    start = 1'b0;
    inv_en = 1'b1;
    check_idle("reset");
  endtask

  task automatic run_program(input string name, input int eq_mode, input bit abort_ld);
    exp_t e;
    bit   rd;
    int   ncyc;
    build_model(eq_mode);
    do_reset();
    ptr = 0;
    ncyc = 0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    foreach (exp_q[k]) begin
      e = exp_q[k];
      eq_flag = e.eq;
      check({name, ".state"}, 32'(state_out), 32'(e.st));
      check({name, ".ctrl"}, 32'(ctrlsig), 32'(e.ctrl));
      check({name, ".pc_inc"}, 32'(pc_inc), 32'(e.pc));
      check({name, ".halted"}, 32'(halted), 32'(e.st == 6));
      ncyc++;
      if (abort_ld && e.st == 4) begin
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_idle({name, ".abort"});
        for (int j = 0; j < 4; j++) begin
          @(posedge clk);
          #1;
          check({name, ".post_state"}, 32'(state_out), 32'd0);
          check({name, ".post_ctrl"}, 32'(ctrlsig), 32'd0);
        end
        $display("prog %s: reset in ARG_LD after %0d cycles", name, ncyc);
        return;
      end
      rd = e.ctrl[8];
      // Spurious start pulses while busy must be ignored.
      start = (e.st != 6) && ($urandom_range(0, 3) == 0);
      @(posedge clk);
      #1;
      start = 1'b0;
      if (rd) begin
        instr_in = (ptr < prog.size()) ? prog[ptr] : 8'($urandom);
        ptr++;
      end else begin
        instr_in = 8'($urandom);
      end
    end
    // Parked in HALT: start has no effect.
    for (int j = 0; j < 6; j++) begin
      start = (j == 2);
      check({name, ".halt_state"}, 32'(state_out), 32'd6);
      check({name, ".halt_ctrl"}, 32'(ctrlsig), 32'd0);
      check({name, ".halt_pc_inc"}, 32'(pc_inc), 32'd0);
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    $display("prog %s: %0d bytes, %0d cycles to HALT", name, prog.size(), ncyc);
  endtask

  initial begin
    int n_ins;
    int cls;
    repeat (2) @(posedge clk);
    #1;

    prog = '{8'h20, 8'h03, 8'hE0};
    run_program("inc", 2, 1'b0);
    prog = '{8'h00, 8'hE0};
    run_program("nop_halt", 2, 1'b0);
    prog = '{8'hC0, 8'h10, 8'hE0};
    run_program("jeq_eq1", 1, 1'b0);
    run_program("jeq_eq0", 0, 1'b0);
    prog = '{8'hA0, 8'h05, 8'hE0};
    run_program("jmp", 2, 1'b0);
    prog = '{8'h60, 8'h7F, 8'hE0};
    run_program("wtr_reset", 2, 1'b1);

    for (int r = 0; r < 30; r++) begin
      prog.delete();
      n_ins = $urandom_range(3, 8);
      for (int k = 0; k < n_ins; k++) begin
        cls = $urandom_range(0, 6);
        prog.push_back({3'(cls), 5'($urandom)});
        if (cls != 0) prog.push_back(8'($urandom));
      end
      prog.push_back({3'b111, 5'($urandom)});
      run_program($sformatf("rand%0d", r), 2, 1'b0);
    end

    inv_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
